// File: rtl/bounce_generator.sv
`default_nettype none
// ============================================================================
// Module      : bounce_generator
// Description : Switch-bounce emulator. Each channel follows a clean level
//               command, but every accepted level change first produces a
//               window of pseudo-random toggles on glitchy_out. The output
//               then settles to the commanded level. All channels share one
//               16-bit Fibonacci LFSR, and each channel draws its hold length
//               from its own LFSR slice.
//               WIDTH*HOLD_BITS must not exceed 16.
//               Optional feature macro: BOUNCE_GEN_BYPASS_EN. When it is
//               defined, a bypass input passes clean_in straight to the
//               registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module bounce_generator #(
  parameter int          WIDTH         = 2,
  parameter int          BOUNCE_CYCLES = 40,
  parameter int          HOLD_BITS     = 3,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef BOUNCE_GEN_BYPASS_EN
  input  logic             bypass,
`endif
  input  logic [WIDTH-1:0] clean_in,
  output logic [WIDTH-1:0] glitchy_out,
  output logic [WIDTH-1:0] busy
);

  localparam int C_BCW = $clog2(BOUNCE_CYCLES) + 1;
  localparam int C_HCW = HOLD_BITS + 1;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [15:0]      C_SEED  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [C_BCW-1:0] C_BLOAD = C_BCW'(BOUNCE_CYCLES - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_BOUNCE = 1'b1;

  logic [15:0] r_lfsr;
  logic        w_bypass;

`ifdef BOUNCE_GEN_BYPASS_EN
  assign w_bypass = bypass;
`else
  assign w_bypass = 1'b0;
`endif

  // Shared LFSR advances every cycle once out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= C_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [0:0]       r_state;
      logic [0:0]       w_state_nxt;
      logic             r_out;
      logic             w_out_nxt;
      logic             r_tgt;
      logic             w_tgt_nxt;
      logic [C_BCW-1:0] r_bcnt;
      logic [C_BCW-1:0] w_bcnt_nxt;
      logic [C_HCW-1:0] r_hcnt;
      logic [C_HCW-1:0] w_hcnt_nxt;
      logic [C_HCW-1:0] w_draw;
      logic             w_busy;

      // Hold draw minus one: the counter runs from h-1 down to 0.
      assign w_draw = {1'b0, r_lfsr[gi*HOLD_BITS +: HOLD_BITS]};

      // Channel state register; reset aborts any bounce in progress.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_state <= S_IDLE;
          r_out   <= 1'b0;
          r_tgt   <= 1'b0;
          r_bcnt  <= '0;
          r_hcnt  <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_out   <= w_out_nxt;
          r_tgt   <= w_tgt_nxt;
          r_bcnt  <= w_bcnt_nxt;
          r_hcnt  <= w_hcnt_nxt;
        end
      end

      // Next-state logic: start, restart, toggle or settle the bounce window.
      always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_tgt_nxt   = r_tgt;
        w_bcnt_nxt  = r_bcnt;
        w_hcnt_nxt  = r_hcnt;
        if (w_bypass) begin
          w_state_nxt = S_IDLE;
          w_out_nxt   = clean_in[gi];
          w_tgt_nxt   = clean_in[gi];
          w_bcnt_nxt  = '0;
          w_hcnt_nxt  = '0;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (clean_in[gi] != r_out) begin
                w_state_nxt = S_BOUNCE;
                w_tgt_nxt   = clean_in[gi];
                w_out_nxt   = ~r_out;
                w_bcnt_nxt  = C_BLOAD;
                w_hcnt_nxt  = w_draw;
              end
            end
            S_BOUNCE: begin
              if (clean_in[gi] != r_tgt) begin
                // The command moved again: restart the window. The hold
                // counter keeps running and rests at zero if it is already
                // there, so it cannot wrap.
                w_tgt_nxt  = clean_in[gi];
                w_bcnt_nxt = C_BLOAD;
                if (r_hcnt != '0) begin
                  w_hcnt_nxt = r_hcnt - 1'b1;
                end
              end else if (r_bcnt == '0) begin
                w_out_nxt   = r_tgt;
                w_state_nxt = S_IDLE;
              end else if (r_hcnt == '0) begin
                w_out_nxt  = ~r_out;
                w_hcnt_nxt = w_draw;
                w_bcnt_nxt = r_bcnt - 1'b1;
              end else begin
                w_hcnt_nxt = r_hcnt - 1'b1;
                w_bcnt_nxt = r_bcnt - 1'b1;
              end
            end
            default: begin
              w_state_nxt = S_IDLE;
            end
          endcase
        end
      end

      // Outputs: busy only while bouncing (and never while bypassed).
      always_comb begin
        w_busy = (r_state == S_BOUNCE) && !w_bypass;
      end

      assign busy[gi]        = w_busy;
      assign glitchy_out[gi] = r_out;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/bounce_generator.md
Name: bounce_generator

Overview:
- Synthesizable switch-bounce emulator: the counterpart that produces the glitchy signals a button debouncer consumes.
- Takes clean per-channel level commands and, on each level change, drives a pseudo-randomly toggling output for a fixed window, then settles to the commanded level.
- Used on-board to self-test the synchronizer -> debouncer -> edge-detector input chain without physical buttons.
- Also reusable as a deterministic stimulus source in benches.

Parameters:
- WIDTH, 2, number of independent channels; WIDTH*HOLD_BITS <= 16.
- BOUNCE_CYCLES, 40, length of the bounce window in clk cycles; must be >= 1.
- HOLD_BITS, 3, random hold length per toggle is 1..2^HOLD_BITS cycles.
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- clean_in  input  WIDTH  commanded clean level per channel.
- glitchy_out  output  WIDTH  emulated bouncing switch output, registered.
- busy  output  WIDTH  per-channel: high while the channel is in BOUNCE.

Behaviour:
- Reset is synchronous and active-low: on a posedge clk with rst_n=0:
  - glitchy_out=0, busy=0.
  - Every channel goes to IDLE; hold and bounce counters are cleared.
  - lfsr=SEED (or 1 if SEED is 0).
  - Reset mid-bounce aborts the bounce immediately.
- LFSR: shared, 16-bit Fibonacci, shifts left every cycle out of reset; new bit = l[15]^l[13]^l[12]^l[10].
- Channel i hold draw: h_i = l[i*HOLD_BITS +: HOLD_BITS] + 1, range 1..2^HOLD_BITS. Draws use the LFSR value present in the same cycle.
- Per-channel FSM has states IDLE and BOUNCE. busy[i] is high only in BOUNCE.
- IDLE:
  - If clean_in[i]==glitchy_out[i], nothing changes.
  - Otherwise, on the next edge: state=BOUNCE, target=clean_in[i], glitchy_out[i] toggles (first bounce edge), bcnt=BOUNCE_CYCLES-1, hcnt=h_i-1.
- BOUNCE, evaluated each edge in this priority order:
  1. If clean_in[i]!=target: target=clean_in[i], bcnt=BOUNCE_CYCLES-1; the window restarts and the hold counter keeps running.
  2. Else if bcnt==0: glitchy_out[i]=target, state=IDLE.
  3. Else if hcnt==0: glitchy_out[i] toggles, hcnt=h_i-1, bcnt decrements.
  4. Else: hcnt and bcnt decrement.
- Timing: if the change is accepted at edge k and clean_in is stable afterwards, glitchy_out[i]==target and busy[i]==0 from edge k+BOUNCE_CYCLES onward.
- In BOUNCE, consecutive toggles are spaced 1..2^HOLD_BITS cycles apart.
- glitchy_out never changes in IDLE.
- BOUNCE_CYCLES=1: a single toggle, then settled at the next edge.
- A clean_in pulse that returns to the original level mid-bounce still bounces for a full restarted window and ends at the original level.
- Channels are fully independent; simultaneous changes on several channels are all handled in the same cycle.
- Counter widths are $clog2(BOUNCE_CYCLES)+1 and HOLD_BITS+1; no wrap-around is possible.

Optional Feature:
- Macro BOUNCE_GEN_BYPASS_EN.
- Defined:
  - Adds port bypass (input, 1).
  - While bypass=1: glitchy_out <= clean_in with one-cycle register latency; all channels forced to IDLE; busy=0.
  - When bypass deasserts, channels resume from IDLE.
- Undefined: no bypass port and no bypass logic.

Test Plan:
- Reset, clean_in=2'b00 for 50 cycles -> glitchy_out=00, busy=00 throughout.
- clean_in[0] 0->1 accepted at edge k, defaults -> busy[0]=1 over edges k..k+39; glitchy_out[0]=1 and busy[0]=0 from edge k+40 and stable 100 further cycles; toggle gaps all within 1..8 cycles.
- clean_in[1] 0->1, then back to 0 ten cycles later -> window restarts; busy[1] falls 40 edges after the second change; glitchy_out[1] ends at 0; channel 0 untouched.
- Both channels change in the same cycle -> both busy; each settles 40 edges later to its commanded value; toggle patterns differ (different LFSR slices).
- rst_n=0 for one edge at cycle 15 of a bounce -> glitchy_out=00, busy=00 next cycle; clean_in=2'b11 then triggers fresh 40-cycle bounces on both channels.
- Feed glitchy_out into debouncer (SAMPLE_CNT_MAX=10, PULSE_CNT_MAX=4) with BOUNCE_CYCLES=20, HOLD_BITS=2 -> debounced output rises exactly once per clean_in rise, never during bounce-only windows.
